// File: rtl/router_pkg.sv
// Shared constants and helpers for the router FIFO slice: header field slicing
// and pointer/level width derivation.
package router_pkg;

  localparam int unsigned ADDR_BITS = 2;

  function automatic int unsigned ptr_bits(int unsigned depth);
    return $clog2(depth);
  endfunction

  // Level needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned level_bits(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] hdr_payload_len(logic [31:0] hdr, int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (hdr & mask) >> ADDR_BITS;
  endfunction

  function automatic logic [ADDR_BITS-1:0] hdr_dest_addr(logic [31:0] hdr);
    return hdr[ADDR_BITS-1:0];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read, plus a
// combinational view of the entry at the read address for look-ahead decoding.
module router_fifo_mem #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic [WIDTH-1:0]         head
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (clear) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

  assign head = mem_q[raddr];

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware per-destination FIFO: stores each byte with its header marker and
// tracks packet boundaries on the read side from the header's payload length.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   soft_reset,
  input  logic                   write_enb,
  input  logic                   read_enb,
  input  logic                   lfd_state,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   pkt_active,
  output logic                   pkt_done,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   framing_err
);

  localparam int unsigned PW = ptr_bits(DEPTH);
  localparam int unsigned LW = level_bits(DEPTH);
  localparam int unsigned RW = WIDTH - 1;
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);
  localparam logic [LW-1:0] AfLvl   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AeLvl   = LW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    fill_q, fill_d;
  logic [RW-1:0]    rc_q, rc_d;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, unf_q, ferr_q, done_q;
  logic             frame_evt, done_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH:0]   head, rdata;
  logic [31:0]      pld_len;
  logic             unused_lfd;

  // Acceptance uses the registered flags; soft_reset swallows both requests.
  assign wr_ok = write_enb && !full_q && !soft_reset;
  assign rd_ok = read_enb && !empty_q && !soft_reset;

  router_fifo_mem #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .clear (soft_reset),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata ({lfd_state, data_in}),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (rdata),
    .head  (head)
  );

  always_comb begin
    fill_d = fill_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + LW'(1);
      2'b01:   fill_d = fill_q - LW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Packet state register: IDLE when rc_q == 0, IN_PKT otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc_q <= '0;
    end else if (soft_reset) begin
      rc_q <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign pld_len = hdr_payload_len(32'(head[WIDTH-1:0]), WIDTH);

  always_comb begin
    rc_d      = rc_q;
    frame_evt = 1'b0;
    done_d    = 1'b0;
    if (rd_ok) begin
      if (head[WIDTH]) begin
        rc_d      = RW'(pld_len + 32'd1);
        frame_evt = (rc_q != '0);
      end else if (rc_q != '0) begin
        rc_d   = rc_q - RW'(1);
        done_d = (rc_q == RW'(1));
      end else begin
        frame_evt = 1'b1;
      end
    end
  end

  always_comb begin
    pkt_active = (rc_q != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      fill_q  <= fill_d;
      full_q  <= (fill_d == FullLvl);
      empty_q <= (fill_d == '0);
      af_q    <= (fill_d >= AfLvl);
      ae_q    <= (fill_d <= AeLvl);
      ovf_q   <= ovf_q | (write_enb && full_q);
      unf_q   <= unf_q | (read_enb && empty_q);
      ferr_q  <= ferr_q | frame_evt;
      done_q  <= done_d;
    end
  end

  assign unused_lfd   = rdata[WIDTH];
  assign data_out     = rdata[WIDTH-1:0];
  assign fill_level   = fill_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign pkt_done     = done_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign framing_err  = ferr_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Self-checking bench: a DEPTH=16 and a DEPTH=4 instance driven by directed and
// random steps, compared against a queue-style behavioural model.
module tb_router_fifo_pkt;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] we, re, lfd, srst;
  logic [7:0] din [2];

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, act0, done0, ovf0, unf0, ferr0;
  logic       full1, empty1, af1, ae1, act1, done1, ovf1, unf1, ferr1;
  logic [4:0] fill0;
  logic [2:0] fill1;

  always #5 clock = ~clock;

  router_fifo_pkt #(.WIDTH(8), .DEPTH(16)) dut0 (
    .clock(clock), .reset(reset), .soft_reset(srst[0]), .write_enb(we[0]),
    .read_enb(re[0]), .lfd_state(lfd[0]), .data_in(din[0]), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .fill_level(fill0), .pkt_active(act0), .pkt_done(done0), .overflow(ovf0),
    .underflow(unf0), .framing_err(ferr0)
  );

  router_fifo_pkt #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3)) dut1 (
    .clock(clock), .reset(reset), .soft_reset(srst[1]), .write_enb(we[1]),
    .read_enb(re[1]), .lfd_state(lfd[1]), .data_in(din[1]), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .fill_level(fill1), .pkt_active(act1), .pkt_done(done1), .overflow(ovf1),
    .underflow(unf1), .framing_err(ferr1)
  );

  // Behavioural model: per-instance circular store with head index and count.
  int         depth [2] = '{16, 4};
  int         afth  [2] = '{14, 3};
  int         aeth  [2] = '{2, 2};
  logic [8:0] mmem  [2][16];
  int         mhd   [2];
  int         mcnt  [2];
  int         mrc   [2];
  logic [7:0] mdout [2];
  bit         mdone [2];
  bit         movf  [2];
  bit         munf  [2];
  bit         mferr [2];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int i);
    mhd[i] = 0; mcnt[i] = 0; mrc[i] = 0; mdout[i] = 8'h00;
    mdone[i] = 0; movf[i] = 0; munf[i] = 0; mferr[i] = 0;
  endtask

  task automatic model_step(input int i, input bit w, input bit r, input bit l,
                            input logic [7:0] d, input bit s);
    bit wok, rok;
    int tail;
    logic [8:0] e;
    if (s) begin
      model_clear(i);
      return;
    end
    wok  = w && (mcnt[i] != depth[i]);
    rok  = r && (mcnt[i] != 0);
    tail = (mhd[i] + mcnt[i]) % depth[i];
    if (w && !wok) movf[i] = 1;
    if (r && !rok) munf[i] = 1;
    mdone[i] = 0;
    if (rok) begin
      e = mmem[i][mhd[i]];
      mdout[i] = e[7:0];
      mhd[i] = (mhd[i] + 1) % depth[i];
      mcnt[i]--;
      if (e[8]) begin
        if (mrc[i] != 0) mferr[i] = 1;
        mrc[i] = int'(e[7:2]) + 1;
      end else if (mrc[i] != 0) begin
        if (mrc[i] == 1) mdone[i] = 1;
        mrc[i]--;
      end else begin
        mferr[i] = 1;
      end
    end
    if (wok) begin
      mmem[i][tail] = {l, d};
      mcnt[i]++;
    end
  endtask

  task automatic check_all(input int i);
    logic [7:0] o_dout;
    logic [31:0] o_fill;
    logic o_full, o_empty, o_af, o_ae, o_act, o_done, o_ovf, o_unf, o_ferr;
    if (i == 0) begin
      o_dout = dout0; o_fill = 32'(fill0); o_full = full0; o_empty = empty0; o_af = af0;
      o_ae = ae0; o_act = act0; o_done = done0; o_ovf = ovf0; o_unf = unf0; o_ferr = ferr0;
    end else begin
      o_dout = dout1; o_fill = 32'(fill1); o_full = full1; o_empty = empty1; o_af = af1;
      o_ae = ae1; o_act = act1; o_done = done1; o_ovf = ovf1; o_unf = unf1; o_ferr = ferr1;
    end
    chk("data_out", 32'(o_dout), 32'(mdout[i]));
    chk("fill_level", o_fill, mcnt[i]);
    chk("full", 32'(o_full), 32'(mcnt[i] == depth[i]));
    chk("empty", 32'(o_empty), 32'(mcnt[i] == 0));
    chk("almost_full", 32'(o_af), 32'(mcnt[i] >= afth[i]));
    chk("almost_empty", 32'(o_ae), 32'(mcnt[i] <= aeth[i]));
    chk("pkt_active", 32'(o_act), 32'(mrc[i] != 0));
    chk("pkt_done", 32'(o_done), 32'(mdone[i]));
    chk("overflow", 32'(o_ovf), 32'(movf[i]));
    chk("underflow", 32'(o_unf), 32'(munf[i]));
    chk("framing_err", 32'(o_ferr), 32'(mferr[i]));
  endtask

  task automatic idle_inputs();
    we = 2'b00; re = 2'b00; lfd = 2'b00; srst = 2'b00;
    din[0] = 8'h00; din[1] = 8'h00;
  endtask

  task automatic cyc(input int i, input bit w, input bit r, input bit l,
                     input logic [7:0] d, input bit s);
    idle_inputs();
    we[i] = w; re[i] = r; lfd[i] = l; din[i] = d; srst[i] = s;
    @(posedge clock);
    model_step(i, w, r, l, d, s);
    #1;
    check_all(i);
  endtask

  task automatic wr(input int i, input bit l, input logic [7:0] d);
    cyc(i, 1'b1, 1'b0, l, d, 1'b0);
  endtask

  task automatic rd(input int i);
    cyc(i, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_clear(0);
    model_clear(1);
    #12;
    check_all(0);
    check_all(1);
    @(negedge clock);
    reset = 1'b0;

    // Full packet of 16 bytes fills the FIFO; a 17th write overflows.
    wr(0, 1'b1, 8'h3A);
    for (int k = 0; k < 15; k++) wr(0, 1'b0, 8'($urandom));
    wr(0, 1'b0, 8'hEE);
    for (int k = 0; k < 16; k++) rd(0);
    rd(0);
    cyc(0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1);

    // Preload, simultaneous traffic, then simultaneous access while empty.
    wr(0, 1'b1, 8'h08);
    wr(0, 1'b0, 8'h11);
    wr(0, 1'b0, 8'h22);
    for (int k = 0; k < 3; k++) cyc(0, 1'b1, 1'b1, 1'b0, 8'(8'h30 + k), 1'b0);
    for (int k = 0; k < 3; k++) rd(0);
    cyc(0, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0);
    rd(0);
    cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Header arriving mid-packet reloads the count and flags a framing error.
    wr(0, 1'b1, 8'h10);
    wr(0, 1'b0, 8'hA1);
    wr(0, 1'b0, 8'hA2);
    wr(0, 1'b1, 8'h05);
    wr(0, 1'b0, 8'hB1);
    wr(0, 1'b0, 8'hB2);
    for (int k = 0; k < 6; k++) rd(0);

    // Soft reset flushes stored data and sticky errors.
    for (int k = 0; k < 10; k++) wr(0, 1'b0, 8'($urandom));
    rd(0);
    cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset asserted between edges while a read is requested.
    wr(0, 1'b1, 8'h0C);
    wr(0, 1'b0, 8'h9D);
    rd(0);
    idle_inputs();
    re[0] = 1'b1;
    #3;
    reset = 1'b1;
    model_clear(0);
    model_clear(1);
    #1;
    check_all(0);
    check_all(1);
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;

    // Random traffic on the 16-deep instance.
    for (int k = 0; k < 300; k++)
      cyc(0, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
          8'($urandom), ($urandom_range(0, 49) == 0));

    // Wrap-around on the 4-deep instance.
    for (int n = 0; n < 10; n++) begin
      wr(1, 1'b1, 8'($urandom_range(0, 3)));
      for (int k = 0; k < 4; k++) wr(1, 1'b0, 8'($urandom));
      for (int k = 0; k < 5; k++) rd(1);
    end
    for (int k = 0; k < 150; k++)
      cyc(1, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
          8'($urandom), ($urandom_range(0, 39) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
